vlsi_serial_subtractor: RTL and testbench
=========================================

// Module: vlsi_serial_subtractor
// PURPOSE
//  Bit-serial subtractor: the inverse arithmetic companion to the combinational half-adder slice.
//  Accepts two WIDTH-bit operands over a valid/ready handshake and computes diff = a - b LSB-first.
//  Uses one full-subtractor cell, one bit per clock. Returns diff and final borrow over a second handshake.
//  Sits behind the tt_um pin wrapper: ui_in/uio_in supply operands, uo_out carries the result.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..16
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept operands; high only in IDLE
//  a          in   WIDTH  minuend; sampled on accept
//  b          in   WIDTH  subtrahend; sampled on accept
//  out_valid  out  1      diff/borrow valid; high only in DONE
//  out_ready  in   1      consumer takes the result
//  diff       out  WIDTH  a - b modulo 2^WIDTH (or saturated, see CONFIGURATION)
//  borrow     out  1      1 when a < b (unsigned)
//  busy       out  1      high in SHIFT
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; diff=0; borrow=0; bit counter=0; operand registers=0.
//  - FSM IDLE -> SHIFT when in_valid&&in_ready (accept edge): load a_sr=a, b_sr=b, borrow_r=0, cnt=0.
//  - SHIFT: each edge computes d=a_sr[0]^b_sr[0]^borrow_r.
//    Next borrow is (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow_r).
//    d shifts into the MSB of the result register; a_sr/b_sr shift right; cnt++.
//  - SHIFT -> DONE on the edge where cnt==WIDTH-1, which processes the last bit.
//    out_valid rises exactly WIDTH cycles after the accept edge.
//  - DONE: diff/borrow stable while out_valid=1 and out_ready=0.
//    DONE -> IDLE on the edge with out_ready=1. out_valid falls and in_ready rises in the next cycle.
//  - No accept in the same cycle as result handoff; minimum issue interval is WIDTH+2 cycles.
//  - in_valid during SHIFT/DONE is ignored; a, b, in_valid are don't-care outside IDLE.
//  - out_ready outside DONE is ignored.
//  - diff and borrow hold the last result after DONE->IDLE until the next SHIFT completes.
//    They are only meaningful when out_valid=1.
//  - rst asserted mid-SHIFT or in DONE aborts the operation and applies all reset values next edge.
//    No partial result is ever presented.
//  - Wrap-around: a=0,b=1 gives diff=all-ones, borrow=1. Equal operands give diff=0, borrow=0.
// CONFIGURATION
//  - Macro VLSI_SERIAL_SUB_SAT_EN. When defined, the result saturates.
//    On entry to DONE with final borrow=1, diff is forced to 0; borrow still reports 1.
//  - Undefined: diff is the raw modulo-2^WIDTH result. The saturation logic is absent.
//  - Handshake timing is identical in both builds.
// STRUCTURE
//  - Package vlsi_pkg: state typedef (IDLE, SHIFT, DONE; 2-bit encoding) and constant DEFAULT_WIDTH=8.
//    The counter width is $clog2(WIDTH).
//  - Sub-module vlsi_full_subtractor: combinational cell.
//    Inputs x, y, bin; outputs d, bout. This is the single instance inside the datapath.
//  - Top contains the FSM, counter, shift registers and the result register.
// TESTING
//  1. WIDTH=8, a=8'h05, b=8'h03, out_ready=1 -> out_valid 8 cycles after accept; diff=8'h02, borrow=0.
//  2. a=8'h03, b=8'h05 -> diff=8'hFE, borrow=1.
//     With VLSI_SERIAL_SUB_SAT_EN: diff=8'h00, borrow=1.
//  3. a=8'hFF, b=8'hFF, then a=8'h00, b=8'h01 back-to-back ->
//     diff=8'h00/borrow=0, then diff=8'hFF/borrow=1. Second in_ready rises 1 cycle after first handoff.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, diff, borrow stable.
//     in_valid pulses with a=8'hAA are ignored; the handoff occurs on the first out_ready=1 edge.
//  5. rst pulse 3 cycles into SHIFT (a=8'h80, b=8'h01) -> next cycle: IDLE, in_ready=1, out_valid=0, diff=0.
//     A new op a=8'h10, b=8'h01 then yields diff=8'h0F.
//  6. in_valid held high during SHIFT with changing a/b -> result reflects only the operands sampled on the accept edge.

Source files
------------

// File: rtl/vlsi_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and default width.
package vlsi_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : vlsi_pkg

// File: rtl/vlsi_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
module vlsi_full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : vlsi_full_subtractor

// File: rtl/vlsi_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock through a
// single full-subtractor cell, with valid/ready handshakes on both sides.
// Optional build macro VLSI_SERIAL_SUB_SAT_EN: clamp diff to zero when the
// final borrow is set (borrow still reports 1). Handshake timing is unchanged.
module vlsi_serial_subtractor
    import vlsi_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    // Minuend register doubles as the result register: each difference bit
    // enters at the MSB while the consumed minuend bit leaves at the LSB.
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic             brw_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last_bit;

    vlsi_full_subtractor u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign accept   = in_valid && (state_q == IDLE);
    assign last_bit = (cnt_q == LAST_BIT);

    // Next-state and handshake outputs, decoded from the current state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath: load operands on accept, shift one bit per SHIFT cycle,
    // capture the finished result on the final bit so diff only ever shows
    // complete results.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            a_sr_q <= a;
            b_sr_q <= b;
            brw_q  <= 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_q  <= cnt_q + 1'b1;
            a_sr_q <= {cell_d, a_sr_q[WIDTH-1:1]};
            b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
            brw_q  <= cell_bout;
            if (last_bit) begin
                borrow_q <= cell_bout;
`ifdef VLSI_SERIAL_SUB_SAT_EN
                diff_q <= cell_bout ? '0 : {cell_d, a_sr_q[WIDTH-1:1]};
`else
                diff_q <= {cell_d, a_sr_q[WIDTH-1:1]};
`endif
            end
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule : vlsi_serial_subtractor

// File: tb/tb_vlsi_serial_subtractor.sv
// Self-checking bench for vlsi_serial_subtractor: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_vlsi_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;

    int checks = 0;
    int errors = 0;

    vlsi_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        r = x - y;
`ifdef VLSI_SERIAL_SUB_SAT_EN
        if (x < y) r = '0;
`endif
        return r;
    endfunction

    // Called at a negedge. Issues one operation, optionally with junk inputs
    // during SHIFT and bp cycles of backpressure in DONE, then hands off.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input int bp, input bit junk);
        logic [W-1:0] ed;
        logic         eb;
        int           lat;
        ed = model_diff(x, y);
        eb = (x < y);
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", in_ready, 1);
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("busy_shift", busy, 1);
        check("in_ready_shift", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (junk) begin
                a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
                out_ready = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("latency", lat, W);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1; a = 8'hAA; b = W'($urandom);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_diff", diff, ed);
            check("bp_borrow", borrow, eb);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
        check("hold_diff", diff, ed);
        check("hold_borrow", borrow, eb);
        $display("op a=%02h b=%02h diff=%02h borrow=%0b exp_diff=%02h exp_borrow=%0b lat=%0d bp=%0d",
                 x, y, diff, borrow, ed, eb, lat, bp);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h05, 8'h03, 0, 1'b0);
        run_op(8'h03, 8'h05, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h00, 8'h01, 0, 1'b0);
        run_op(8'h5A, 8'h3C, 5, 1'b0);

        // Abort mid-SHIFT with reset; last result (from 5A-3C) must be cleared.
        a = 8'h80; b = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        $display("abort a=80 b=01 diff=%02h out_valid=%0b", diff, out_valid);
        run_op(8'h10, 8'h01, 0, 1'b0);

        run_op(8'hC3, 8'h5A, 1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vlsi_serial_subtractor
